// File: rtl/tune_player.sv
// tune_player: ROM-driven piezo tune sequencer with selectable tunes, inter-note gaps, looping and abort.
// DUR_SHIFT sets how far FAST_SIM shortens every note duration.
module tune_player #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_TUNES   = 2,
  parameter int MAX_NOTES   = 8,
  parameter int GAP_CLKS    = 0,
  parameter bit FAST_SIM    = 1'b0,
  parameter int DUR_SHIFT   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic [(NUM_TUNES > 1 ? $clog2(NUM_TUNES) : 1)-1:0] tune_sel,
  input  logic loop_en,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic [(MAX_NOTES > 1 ? $clog2(MAX_NOTES) : 1)-1:0] note_idx,
  output logic piezo,
  output logic piezo_n
);
  localparam int TW = NUM_TUNES > 1 ? $clog2(NUM_TUNES) : 1;
  localparam int IW = MAX_NOTES > 1 ? $clog2(MAX_NOTES) : 1;
  localparam int PW = $clog2(CLK_FREQ_HZ / 500);
  localparam int DW = 26;

  typedef enum logic [1:0] {IDLE, PLAY, GAP, FIN} state_t;

  // Periods are tabulated at 50 MHz and rescaled to CLK_FREQ_HZ.
  function automatic int raw_p(input int t, input int i);
    raw_p = 0;
    if (t == 0)
      case (i)
        0: raw_p = 31888;
        1: raw_p = 23889;
        2: raw_p = 18961;
        3: raw_p = 15944;
        4: raw_p = 18961;
        5: raw_p = 15944;
        default: raw_p = 0;
      endcase
    else if (t == 1 && NUM_TUNES > 1)
      case (i)
        0: raw_p = 47755;
        1: raw_p = 63776;
        default: raw_p = 0;
      endcase
  endfunction

  function automatic int raw_d(input int t, input int i);
    raw_d = 0;
    if (t == 0)
      case (i)
        0, 1, 2: raw_d = 1 << 23;
        3: raw_d = (1 << 23) + (1 << 22);
        4: raw_d = 1 << 22;
        5: raw_d = 1 << 25;
        default: raw_d = 0;
      endcase
    else if (t == 1 && NUM_TUNES > 1)
      case (i)
        0: raw_d = 1 << 22;
        1: raw_d = 1 << 23;
        default: raw_d = 0;
      endcase
  endfunction

  function automatic logic [PW-1:0] per(input int t, input int i);
    per = PW'((raw_p(t, i) * (CLK_FREQ_HZ / 50_000)) / 1000);
  endfunction

  function automatic logic [DW-1:0] dur(input int t, input int i);
    dur = DW'(FAST_SIM ? raw_d(t, i) >> DUR_SHIFT : raw_d(t, i));
  endfunction

  state_t state_q, state_d;
  logic [TW-1:0] tune_q, tune_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] pcnt_q, pcnt_d, p_cur, p_nxt;
  logic [DW-1:0] dcnt_q, dcnt_d, d_cur;
  logic piezo_q, piezo_d, done_q, done_d, busy_q, busy_d, stop;

  always_comb begin
    state_d = state_q;
    tune_d  = tune_q;
    idx_d   = idx_q;
    pcnt_d  = '0;
    dcnt_d  = '0;
    p_cur   = per(int'(tune_q), int'(idx_q));
    d_cur   = dur(int'(tune_q), int'(idx_q));
    stop    = idx_q == IW'(MAX_NOTES - 1) || dur(int'(tune_q), int'(idx_q) + 1) == '0;
    case (state_q)
      IDLE: if (go) begin
        tune_d  = tune_sel;
        idx_d   = '0;
        state_d = dur(int'(tune_sel), 0) == '0 ? FIN : PLAY;
      end
      PLAY: begin
        pcnt_d = pcnt_q == p_cur - 1'b1 ? '0 : pcnt_q + 1'b1;
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == d_cur - 1'b1) begin
          pcnt_d  = '0;
          dcnt_d  = '0;
          state_d = stop ? FIN : (GAP_CLKS > 0 ? GAP : PLAY);
          idx_d   = state_d == PLAY ? idx_q + 1'b1 : idx_q;
        end
      end
      GAP: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DW'(GAP_CLKS - 1)) begin
          dcnt_d  = '0;
          state_d = PLAY;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = done_q ? IDLE : (dur(int'(tune_q), 0) == '0 ? FIN : PLAY);
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      pcnt_d  = '0;
      dcnt_d  = '0;
    end
    // loop_en is sampled on entry to FIN so that done can be a registered output
    p_nxt   = per(int'(tune_d), int'(idx_d));
    done_d  = state_d == FIN && !loop_en;
    busy_d  = state_d != IDLE;
    piezo_d = state_d == PLAY && pcnt_d < (p_nxt >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tune_q  <= '0;
      idx_q   <= '0;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
      piezo_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tune_q  <= tune_d;
      idx_q   <= idx_d;
      pcnt_q  <= pcnt_d;
      dcnt_q  <= dcnt_d;
      piezo_q <= piezo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;
  assign piezo    = piezo_q;
  assign piezo_n  = ~piezo_q;
endmodule

// File: tb/tb_tune_player.sv
// tb_tune_player: directed checks of tune timing, gaps, looping, abort, empty tune and reset.
module tb_tune_player;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0, loop_en = 1'b0, abort = 1'b0;
  logic [1:0] tune_sel = 2'd0;
  logic busy, done, piezo, piezo_n;
  logic [2:0] note_idx;
  int n_cmp = 0, n_bad = 0, n_done = 0, t = 0, z;
  int st [6] = '{1, 3049, 6097, 9145, 13217, 15241};

  tune_player #(
    .CLK_FREQ_HZ(1_000_000), .NUM_TUNES(3), .MAX_NOTES(8),
    .GAP_CLKS(1000), .FAST_SIM(1'b1), .DUR_SHIFT(12)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .tune_sel(tune_sel), .loop_en(loop_en), .abort(abort),
    .busy(busy), .done(done), .note_idx(note_idx), .piezo(piezo), .piezo_n(piezo_n)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic to(input int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic start(input logic [1:0] sel);
    @(negedge clk);
    tune_sel = sel;
    go = 1'b1;
    t = 0;
    to(1);
    go = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_piezo"}, piezo, 0);
    chk({tag, "_piezo_n"}, piezo_n, 1);
    chk({tag, "_idx"}, note_idx, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    idle_chk("in_rst");
    rst = 1'b0;
    @(negedge clk);
    idle_chk("rst");
    go = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    go = 1'b0;
    abort = 1'b0;
    idle_chk("go_abort");

    start(2'd0);
    chk("f_busy", busy, 1);
    chk("f_piezo", piezo, 1);
    chk("f_piezo_n", piezo_n, 0);
    chk("f_idx0", note_idx, 0);
    to(318);  chk("f_hi_end", piezo, 1);
    to(319);  chk("f_lo_start", piezo, 0);
    to(637);  chk("f_lo_end", piezo, 0);
    to(638);  chk("f_wrap", piezo, 1);
    to(2048); chk("f_n0_last", piezo, 1);
    to(2049); chk("f_gap0", piezo, 0); chk("f_gap0_busy", busy, 1); chk("f_gap0_idx", note_idx, 0);
    for (int k = 1; k < 6; k++) begin
      to(st[k] - 1);
      chk("f_pre_idx", note_idx, k - 1);
      chk("f_pre_piezo", piezo, 0);
      to(st[k]);
      chk("f_idx", note_idx, k);
      chk("f_on", piezo, 1);
    end
    to(23432); chk("f_last_done", done, 0); chk("f_last_idx", note_idx, 5);
    to(23433); chk("f_fin_done", done, 1); chk("f_fin_busy", busy, 1); chk("f_fin_piezo", piezo, 0);
    to(23434); idle_chk("f_after");
    chk("f_done_cnt", n_done, 1);

    start(2'd1);
    chk("e_piezo", piezo, 1);
    to(500);
    go = 1'b1;
    tune_sel = 2'd0;
    to(501);
    go = 1'b0;
    chk("e_ign_busy", busy, 1);
    chk("e_ign_idx", note_idx, 0);
    to(1024); chk("e_n0_last", piezo, 1);
    z = 0;
    for (int k = 1025; k <= 2024; k++) begin
      to(k);
      if (piezo === 1'b0) z++;
    end
    chk("e_gap_len", z, 1000);
    chk("e_gap_idx", note_idx, 0);
    to(2025); chk("e_n1_on", piezo, 1); chk("e_n1_idx", note_idx, 1);
    to(2025 + 636);  chk("e_hi_end", piezo, 1);
    to(2025 + 637);  chk("e_lo_start", piezo, 0);
    to(2025 + 1274); chk("e_lo_end", piezo, 0);
    to(2025 + 1275); chk("e_wrap", piezo, 1);
    to(4072); chk("e_last_done", done, 0);
    to(4073); chk("e_fin_done", done, 1); chk("e_fin_busy", busy, 1);
    to(4074); idle_chk("e_after");
    chk("e_done_cnt", n_done, 2);

    start(2'd2);
    chk("z_done", done, 1);
    chk("z_busy", busy, 1);
    chk("z_piezo", piezo, 0);
    to(2); idle_chk("z_after");
    chk("z_done_cnt", n_done, 3);

    loop_en = 1'b1;
    start(2'd1);
    to(4072); chk("l_idx1", note_idx, 1);
    to(4073); chk("l_fin_done", done, 0); chk("l_fin_busy", busy, 1);
    to(4074); chk("l_restart_idx", note_idx, 0); chk("l_restart_piezo", piezo, 1); chk("l_restart_busy", busy, 1);
    to(6097); chk("l_gap_idx", note_idx, 0);
    to(6098); chk("l_n1_idx", note_idx, 1); chk("l_n1_on", piezo, 1);
    to(6500);
    abort = 1'b1;
    to(6501);
    abort = 1'b0;
    loop_en = 1'b0;
    idle_chk("l_abort");
    to(6503); idle_chk("l_abort_hold");
    chk("l_done_cnt", n_done, 3);

    start(2'd0);
    to(10000); chk("r_idx3", note_idx, 3); chk("r_busy", busy, 1);
    rst = 1'b1;
    to(10001);
    rst = 1'b0;
    idle_chk("r_mid");
    chk("r_done_cnt", n_done, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
